// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the multi-cycle signed divider serving the DIV opcode.
package seq_divider_pkg;

   localparam int         DATA_W  = 32;
   localparam logic [4:0] OPC_DIV = 5'b01111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/seq_divider_abs_neg_unit.sv
// Combinational conditional two's-complement negate: res = neg ? -val : val.
module abs_neg_unit #(
   parameter int W = 33
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_divider.sv
// Restoring signed divider: quotient to z_lo, remainder to z_hi, one iteration per clock.
// Optional macro DIV_ZERO_EXC_EN adds a sticky div_zero flag output.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] z_lo,
   output logic [WIDTH-1:0] z_hi,
   output logic             busy,
`ifdef DIV_ZERO_EXC_EN
   output logic             div_zero,
`endif
   output logic             done
);

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] dvd_r, dvs_r, quo_r;
   logic [WIDTH:0]   rem_r, dvs_abs_r;
   logic             sign_q_r, sign_r_r, zero_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] z_lo_r, z_hi_r;
   logic             busy_r, done_r;

   logic             capture_s, fix_s, done_s, busy_s;
   logic [WIDTH-1:0] neg_a_in_s, neg_a_out_s;
   logic [WIDTH:0]   neg_b_in_s, neg_b_out_s;
   logic             neg_a_s, neg_b_s;
   logic [WIDTH:0]   rem_sh_s, trial_s;
   logic             fits_s;

   // State register
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = PREP;
            else       state_nxt_s = IDLE;
         end
         PREP: state_nxt_s = ITER;
         ITER: begin
            if (cnt_r == CNT_W'(1)) state_nxt_s = FIX;
            else                    state_nxt_s = ITER;
         end
         FIX:     state_nxt_s = DONE;
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output/control decode; busy follows the next state so it tracks PREP..FIX exactly
   always_comb begin
      capture_s = (state_r == IDLE) && start;
      fix_s     = (state_r == FIX);
      done_s    = (state_r == DONE);
      busy_s    = (state_nxt_s == PREP) || (state_nxt_s == ITER) || (state_nxt_s == FIX);
   end

   // Both negate units are time-shared: operand abs in PREP, sign restore in FIX
   always_comb begin
      if (fix_s) begin
         neg_a_in_s = quo_r;
         neg_a_s    = sign_q_r;
         neg_b_in_s = rem_r;
         neg_b_s    = sign_r_r;
      end else begin
         neg_a_in_s = dvd_r;
         neg_a_s    = dvd_r[WIDTH-1];
         neg_b_in_s = {dvs_r[WIDTH-1], dvs_r};
         neg_b_s    = dvs_r[WIDTH-1];
      end
   end

   abs_neg_unit #(.W(WIDTH)) u_neg_a (
      .val (neg_a_in_s),
      .neg (neg_a_s),
      .res (neg_a_out_s)
   );

   abs_neg_unit #(.W(WIDTH + 1)) u_neg_b (
      .val (neg_b_in_s),
      .neg (neg_b_s),
      .res (neg_b_out_s)
   );

   // One restoring step on the shifted {rem,quo} pair
   always_comb begin
      rem_sh_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
      trial_s  = rem_sh_s - dvs_abs_r;
      fits_s   = (rem_sh_s >= dvs_abs_r);
   end

   // Datapath and registered outputs
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         dvd_r     <= {WIDTH{1'b0}};
         dvs_r     <= {WIDTH{1'b0}};
         quo_r     <= {WIDTH{1'b0}};
         rem_r     <= {(WIDTH + 1){1'b0}};
         dvs_abs_r <= {(WIDTH + 1){1'b0}};
         sign_q_r  <= 1'b0;
         sign_r_r  <= 1'b0;
         zero_r    <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
         z_lo_r    <= {WIDTH{1'b0}};
         z_hi_r    <= {WIDTH{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         if (capture_s) begin
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
         end
         case (state_r)
            PREP: begin
               quo_r     <= neg_a_out_s;
               dvs_abs_r <= neg_b_out_s;
               rem_r     <= {(WIDTH + 1){1'b0}};
               cnt_r     <= CNT_W'(WIDTH);
               zero_r    <= (dvs_r == {WIDTH{1'b0}});
            end
            ITER: begin
               rem_r <= fits_s ? trial_s : rem_sh_s;
               quo_r <= {quo_r[WIDTH-2:0], fits_s};
               cnt_r <= cnt_r - CNT_W'(1);
            end
            FIX: begin
               // Divide by zero reports an all-ones quotient regardless of sign
               z_lo_r <= zero_r ? {WIDTH{1'b1}} : neg_a_out_s;
               z_hi_r <= neg_b_out_s[WIDTH-1:0];
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
         busy_r <= busy_s;
         done_r <= done_s;
      end
   end

`ifdef DIV_ZERO_EXC_EN
   logic div_zero_r;

   // Divide-by-zero flag: set with the result, cleared by the next accepted start
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         div_zero_r <= 1'b0;
      end else if (capture_s) begin
         div_zero_r <= 1'b0;
      end else if (fix_s) begin
         div_zero_r <= zero_r;
      end else begin
         div_zero_r <= div_zero_r;
      end
   end

   assign div_zero = div_zero_r;
`endif

   assign z_lo = z_lo_r;
   assign z_hi = z_hi_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule
